// File: rtl/tol_scoreboard_if.sv
// Handshake and expected-memory bus between a DUT lane stream and tol_scoreboard.
// The slave side is the scoreboard; the master side is the stream source plus expected memory.
interface tol_scoreboard_if #(
   parameter int unsigned DW = 512,
   parameter int unsigned AW = 6
);
   logic          dut_valid;
   logic          dut_ready;
   logic [DW-1:0] dut_data;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_data;

   modport slave (
      input  dut_valid,
      input  dut_data,
      input  exp_data,
      output dut_ready,
      output exp_addr
   );

   modport master (
      output dut_valid,
      output dut_data,
      output exp_data,
      input  dut_ready,
      input  exp_addr
   );
endinterface

// File: rtl/tol_scoreboard.sv
// Tolerance scoreboard: compares each accepted multi-lane beat against expected memory with a
// per-field +/-TOL window, counts lane mismatches, and emits checkpoint and pass/done verdicts.
module tol_scoreboard #(
   parameter  int unsigned LANES      = 16,
   parameter  int unsigned FW         = 16,
   parameter  int unsigned CPLX       = 1,
   parameter  int unsigned TOL        = 3,
   parameter  int unsigned BEATS      = 64,
   parameter  int unsigned FAIL_LIMIT = 48,
   parameter  int unsigned CKPT       = 4,
   localparam int unsigned LW         = FW * (1 + CPLX),
   localparam int unsigned CW         = $clog2(FAIL_LIMIT + LANES) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   tol_scoreboard_if.slave      bus,
   output logic [CW-1:0]        err_cnt,
   output logic                 fail,
   output logic                 ckpt,
   output logic                 ckpt_ok,
   output logic                 done,
   output logic                 pass
);

   localparam int unsigned NF = 1 + CPLX;
   localparam int unsigned DW = LANES * LW;
   localparam int unsigned AW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned KW = $clog2(CKPT + 1);
   localparam int unsigned PW = $clog2(LANES + 1);
   localparam logic signed [FW:0] TOL_S = (FW+1)'(TOL);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_END} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    idx_q;
   logic [DW-1:0]    dut_q;
   logic             cmp_vld_q;
   logic [KW-1:0]    ck_cnt_q;
   logic [CW-1:0]    err_cnt_q;
   logic             fail_q, ckpt_q, ckpt_ok_q, done_q, pass_q;

   logic             acc_c, fail_set_c, ck_hit_c, fin_c;
   logic [LANES-1:0] lane_err_c;
   logic [FW-1:0]    dut_f_c, exp_f_c;
   logic signed [FW:0] diff_c;
   logic [PW-1:0]    pop_c;
   logic [CW:0]      sum_c;
   logic [CW-1:0]    cnt_new_c;

   // Ready is forced low while reset is asserted so nothing is accepted in the reset cycle
   assign bus.dut_ready = (state_q == S_RUN) && !rst;
   assign bus.exp_addr  = idx_q;
   assign acc_c         = bus.dut_valid && bus.dut_ready;

   // Per-field signed difference in FW+1 bits so full-scale opposite values cannot wrap
   always_comb begin
      lane_err_c = '0;
      dut_f_c    = '0;
      exp_f_c    = '0;
      diff_c     = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int f = 0; f < NF; f++) begin
            dut_f_c = dut_q[l*LW + f*FW +: FW];
            exp_f_c = bus.exp_data[l*LW + f*FW +: FW];
            diff_c  = {dut_f_c[FW-1], dut_f_c} - {exp_f_c[FW-1], exp_f_c};
            if ((diff_c > TOL_S) || (diff_c < -TOL_S)) begin
               lane_err_c[l] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      pop_c = '0;
      for (int l = 0; l < LANES; l++) begin
         pop_c = pop_c + PW'(lane_err_c[l]);
      end
      sum_c      = (CW+1)'(err_cnt_q) + (CW+1)'(pop_c);
      cnt_new_c  = sum_c[CW] ? {CW{1'b1}} : sum_c[CW-1:0];
      fail_set_c = cmp_vld_q && (cnt_new_c >= CW'(FAIL_LIMIT));
      ck_hit_c   = cmp_vld_q && (ck_cnt_q == KW'(CKPT - 1)) && !fail_set_c;
      fin_c      = (cmp_vld_q && (state_q == S_DRAIN)) || fail_set_c;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN: begin
            if (fail_set_c) begin
               state_d = S_END;
            end else if (acc_c && (idx_q == AW'(BEATS - 1))) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (cmp_vld_q) begin
               state_d = S_END;
            end
         end
         S_END:   state_d = S_END;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_RUN;
         idx_q     <= '0;
         dut_q     <= '0;
         cmp_vld_q <= 1'b0;
         ck_cnt_q  <= '0;
         err_cnt_q <= '0;
         fail_q    <= 1'b0;
         ckpt_q    <= 1'b0;
         ckpt_ok_q <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         // A beat accepted while the previous compare trips fail is discarded
         cmp_vld_q <= acc_c && !fail_set_c;
         if (acc_c) begin
            dut_q <= bus.dut_data;
            if (idx_q != AW'(BEATS - 1)) begin
               idx_q <= idx_q + AW'(1);
            end
         end
         if (cmp_vld_q) begin
            err_cnt_q <= cnt_new_c;
            ck_cnt_q  <= (ck_cnt_q == KW'(CKPT - 1)) ? '0 : ck_cnt_q + KW'(1);
         end
         fail_q    <= fail_q | fail_set_c;
         ckpt_q    <= ck_hit_c;
         ckpt_ok_q <= ck_hit_c && (cnt_new_c == '0);
         done_q    <= done_q | fin_c;
         pass_q    <= pass_q | (fin_c && !fail_set_c && (cnt_new_c == '0));
      end
   end

   assign err_cnt = err_cnt_q;
   assign fail    = fail_q;
   assign ckpt    = ckpt_q;
   assign ckpt_ok = ckpt_ok_q;
   assign done    = done_q;
   assign pass    = pass_q;

endmodule
